// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, mid-bit sampling, configurable word/parity/stop,
// with parity, framing and overrun flags and a one-cycle read handshake.
`timescale 1ns/1ps
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 overrun_error,
  output logic                 busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS + 3);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START_CHK, DATA, PARITY, STOP, LOAD} state_e;

  state_e                 state_q;
  logic [TW-1:0]          timer_q;
  logic [CW-1:0]          bit_cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   prev_rx_q;
  logic                   frame_perr_q;
  logic                   frame_ferr_q;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   data_ready_q;
  logic                   framing_error_q;
  logic                   parity_error_q;
  logic                   overrun_error_q;
  logic                   busy_q;

  logic sample_tick;
  logic parity_exp;

  assign sample_tick = (timer_q == '0);
  // Expected parity bit value; shift_q holds the complete word while in PARITY.
  assign parity_exp  = (^shift_q) ^ (PARITY_ODD != 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      prev_rx_q       <= 1'b0;
      frame_perr_q    <= 1'b0;
      frame_ferr_q    <= 1'b0;
      rx_data_q       <= '0;
      data_ready_q    <= 1'b0;
      framing_error_q <= 1'b0;
      parity_error_q  <= 1'b0;
      overrun_error_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      prev_rx_q <= serial_in;

      // NOTE: non-blocking assignments everywhere, so every term reads pre-edge values.
      if (data_read && state_q != LOAD) begin
        data_ready_q    <= 1'b0;
        framing_error_q <= 1'b0;
        parity_error_q  <= 1'b0;
        overrun_error_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (prev_rx_q && !serial_in) begin
            state_q      <= START_CHK;
            timer_q      <= HALF_LOAD;
            frame_perr_q <= 1'b0;
            frame_ferr_q <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        START_CHK: begin
          if (!sample_tick) begin
            timer_q <= timer_q - 1'b1;
          end else if (serial_in) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q   <= DATA;
            timer_q   <= FULL_LOAD;
            bit_cnt_q <= '0;
          end
        end
        DATA: begin
          if (!sample_tick) begin
            timer_q <= timer_q - 1'b1;
          end else begin
            shift_q <= {serial_in, shift_q[DATA_BITS-1:1]};
            timer_q <= FULL_LOAD;
            if (bit_cnt_q == CW'(DATA_BITS - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (!sample_tick) begin
            timer_q <= timer_q - 1'b1;
          end else begin
            frame_perr_q <= serial_in ^ parity_exp;
            timer_q      <= FULL_LOAD;
            state_q      <= STOP;
          end
        end
        STOP: begin
          if (!sample_tick) begin
            timer_q <= timer_q - 1'b1;
          end else begin
            if (!serial_in) frame_ferr_q <= 1'b1;
            timer_q <= FULL_LOAD;
            if (bit_cnt_q == CW'(STOP_BITS - 1)) begin
              state_q <= LOAD;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        LOAD: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          // A bad frame leaves the previous word and its ready flag untouched.
          if (frame_ferr_q) begin
            framing_error_q <= 1'b1;
            parity_error_q  <= 1'b0;
          end else begin
            rx_data_q       <= shift_q;
            data_ready_q    <= 1'b1;
            parity_error_q  <= frame_perr_q;
            framing_error_q <= 1'b0;
            if (data_read)         overrun_error_q <= 1'b0;
            else if (data_ready_q) overrun_error_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data       = rx_data_q;
  assign data_ready    = data_ready_q;
  assign framing_error = framing_error_q;
  assign parity_error  = parity_error_q;
  assign overrun_error = overrun_error_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: three configurations driven by a frame-level line model,
// compared every cycle against a frame-event reference plus directed literal checks.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] ser;
  logic [2:0] rd;
  wire  [7:0] d0;
  wire  [7:0] d1;
  wire  [4:0] d2;
  wire  [2:0] rdy, fe, pe, ov, bsy;

  // u0: C=16 8N1, u1: C=16 8E1, u2: C=8 5O2
  uart_rx_ctrl #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .serial_in(ser[0]), .data_read(rd[0]), .rx_data(d0),
    .data_ready(rdy[0]), .framing_error(fe[0]), .parity_error(pe[0]),
    .overrun_error(ov[0]), .busy(bsy[0]));
  uart_rx_ctrl #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .serial_in(ser[1]), .data_read(rd[1]), .rx_data(d1),
    .data_ready(rdy[1]), .framing_error(fe[1]), .parity_error(pe[1]),
    .overrun_error(ov[1]), .busy(bsy[1]));
  uart_rx_ctrl #(.CLKS_PER_BIT(8), .DATA_BITS(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .serial_in(ser[2]), .data_read(rd[2]), .rx_data(d2),
    .data_ready(rdy[2]), .framing_error(fe[2]), .parity_error(pe[2]),
    .overrun_error(ov[2]), .busy(bsy[2]));

  function automatic int cpb(input int i);     return (i == 2) ? 8 : 16; endfunction
  function automatic int dbits(input int i);   return (i == 2) ? 5 : 8;  endfunction
  function automatic int par_en(input int i);  return (i == 0) ? 0 : 1;  endfunction
  function automatic int par_odd(input int i); return (i == 2) ? 1 : 0;  endfunction
  function automatic int stop_n(input int i);  return (i == 2) ? 2 : 1;  endfunction

  int cyc = 0;
  int last_rst = 0;
  int n_cmp = 0;
  int n_fail = 0;
  bit rnd_done;

  // Pending frame per instance: start edge, last busy edge, load edge, and its outcome.
  int         p_E [3] = '{-1, -1, -1};
  int         p_B [3] = '{-9, -9, -9};
  int         p_L [3] = '{-9, -9, -9};
  logic [8:0] p_word [3];
  logic [2:0] p_fe;
  logic [2:0] p_pe;

  logic [8:0] e_data [3];
  logic [2:0] e_rdy, e_fe, e_pe, e_ov, e_busy;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) last_rst <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        e_data[i] <= '0;
        e_rdy[i]  <= 1'b0;
        e_fe[i]   <= 1'b0;
        e_pe[i]   <= 1'b0;
        e_ov[i]   <= 1'b0;
        e_busy[i] <= 1'b0;
      end else begin
        if (p_E[i] > last_rst && cyc + 1 == p_L[i]) begin
          if (p_fe[i]) begin
            e_fe[i] <= 1'b1;
            e_pe[i] <= 1'b0;
          end else begin
            e_data[i] <= p_word[i];
            e_rdy[i]  <= 1'b1;
            e_fe[i]   <= 1'b0;
            e_pe[i]   <= p_pe[i];
            e_ov[i]   <= rd[i] ? 1'b0 : (e_ov[i] | e_rdy[i]);
          end
        end else if (rd[i]) begin
          e_rdy[i] <= 1'b0;
          e_fe[i]  <= 1'b0;
          e_pe[i]  <= 1'b0;
          e_ov[i]  <= 1'b0;
        end
        e_busy[i] <= (p_E[i] > last_rst) && (cyc + 1 >= p_E[i]) && (cyc + 1 <= p_B[i]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [13:0] act_vec(input int i);
    case (i)
      0:       return {1'b0, d0, rdy[0], fe[0], pe[0], ov[0], bsy[0]};
      1:       return {1'b0, d1, rdy[1], fe[1], pe[1], ov[1], bsy[1]};
      default: return {4'b0, d2, rdy[2], fe[2], pe[2], ov[2], bsy[2]};
    endcase
  endfunction

  function automatic logic [13:0] exp_vec(input int i);
    return {e_data[i], e_rdy[i], e_fe[i], e_pe[i], e_ov[i], e_busy[i]};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        for (int i = 0; i < 3; i++)
          check($sformatf("model_u%0d", i), 32'(act_vec(i)), 32'(exp_vec(i)));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_edge(input int n);
    while (cyc < n) tick();
  endtask

  task automatic pulse_rd(input int i);
    rd[i] = 1'b1;
    tick();
    rd[i] = 1'b0;
  endtask

  // Drives one frame at line rate; abort_at >= 0 asserts rst during that bit period.
  task automatic send_frame(input int i, input logic [8:0] word, input logic pbit,
                            input logic [1:0] stops, input int abort_at, input bit rd_at_load);
    int         c;
    int         n;
    logic [15:0] fr;
    logic [8:0]  w;
    c  = cpb(i);
    w  = word & 9'((1 << dbits(i)) - 1);
    fr = '1;
    n  = 0;
    fr[n] = 1'b0; n++;
    for (int k = 0; k < dbits(i); k++) begin fr[n] = w[k]; n++; end
    if (par_en(i) != 0) begin fr[n] = pbit; n++; end
    for (int k = 0; k < stop_n(i); k++) begin fr[n] = stops[k]; n++; end
    p_word[i] = w;
    p_fe[i]   = (stop_n(i) == 1) ? ~stops[0] : ~(stops[0] & stops[1]);
    p_pe[i]   = (par_en(i) != 0) && (pbit != ((^w) ^ (par_odd(i) != 0)));
    p_E[i]    = cyc + 1;
    p_B[i]    = cyc + 1 + c / 2 + (dbits(i) + par_en(i) + stop_n(i)) * c;
    p_L[i]    = p_B[i] + 1;
    for (int j = 0; j < n; j++) begin
      if (j == abort_at) begin
        ser[i] = 1'b1;
        rst    = 1'b1;
        tick();
        rst    = 1'b0;
        return;
      end
      ser[i] = fr[j];
      repeat (c) begin
        tick();
        if (rd_at_load) rd[i] = (cyc == p_B[i]);
      end
    end
    ser[i] = 1'b1;
    if (!fr[n-1]) tick();
  endtask

  task automatic glitch(input int i);
    p_E[i] = cyc + 1;
    p_B[i] = cyc + cpb(i) / 2;
    p_L[i] = -9;
    ser[i] = 1'b0;
    repeat (3) tick();
    ser[i] = 1'b1;
    repeat (cpb(i)) tick();
  endtask

  task automatic random_frames(input int i, input int n);
    logic [8:0] w;
    logic       good;
    logic       pbit;
    logic [1:0] stops;
    for (int k = 0; k < n; k++) begin
      if ($urandom % 8 == 0) begin
        glitch(i);
      end else begin
        w     = 9'($urandom) & 9'((1 << dbits(i)) - 1);
        good  = (^w) ^ (par_odd(i) != 0);
        pbit  = good ^ ($urandom % 5 == 0);
        stops = ($urandom % 6 == 0) ? 2'($urandom) : 2'b11;
        send_frame(i, w, pbit, stops, -1, 1'b0);
      end
      repeat ($urandom % (cpb(i) + 1)) tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    ser = '1;
    rd  = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("reset_u0", 32'({d0, rdy[0], fe[0], pe[0], ov[0], bsy[0]}), 0);
    check("reset_u1", 32'({d1, rdy[1], fe[1], pe[1], ov[1], bsy[1]}), 0);
    check("reset_u2", 32'({d2, rdy[2], fe[2], pe[2], ov[2], bsy[2]}), 0);

    fork
      send_frame(0, 9'h0A5, 1'b0, 2'b11, -1, 1'b0);
      begin
        #2;
        at_edge(p_B[0]);
        check("a5_ready_at_stop", 32'(rdy[0]), 0);
        at_edge(p_B[0] + 1);
        check("a5_data", 32'(d0), 32'h0A5);
        check("a5_ready", 32'(rdy[0]), 1);
        check("a5_errors", 32'({fe[0], pe[0], ov[0]}), 0);
        check("a5_busy", 32'(bsy[0]), 0);
      end
    join
    pulse_rd(0);
    check("a5_read_clears_ready", 32'(rdy[0]), 0);

    send_frame(1, 9'h007, 1'b0, 2'b11, -1, 1'b0);
    check("e07_data", 32'(d1), 32'h07);
    check("e07_ready", 32'(rdy[1]), 1);
    check("e07_parity_err", 32'(pe[1]), 1);
    pulse_rd(1);
    check("e07_read_clears_flags", 32'({rdy[1], fe[1], pe[1], ov[1]}), 0);

    send_frame(0, 9'h03C, 1'b0, 2'b10, -1, 1'b0);
    check("3c_framing_err", 32'(fe[0]), 1);
    check("3c_ready_stays", 32'(rdy[0]), 0);
    check("3c_data_keeps", 32'(d0), 32'h0A5);

    pulse_rd(0);
    send_frame(0, 9'h011, 1'b0, 2'b11, -1, 1'b0);
    send_frame(0, 9'h022, 1'b0, 2'b11, -1, 1'b0);
    check("b2b_data", 32'(d0), 32'h22);
    check("b2b_ready", 32'(rdy[0]), 1);
    check("b2b_overrun", 32'(ov[0]), 1);
    pulse_rd(0);
    check("b2b_read_clears_overrun", 32'(ov[0]), 0);
    send_frame(0, 9'h011, 1'b0, 2'b11, -1, 1'b0);
    send_frame(0, 9'h022, 1'b0, 2'b11, -1, 1'b1);
    check("b2b_rd_load_data", 32'(d0), 32'h22);
    check("b2b_rd_load_ready", 32'(rdy[0]), 1);
    check("b2b_rd_load_overrun", 32'(ov[0]), 0);

    glitch(0);
    check("glitch_outputs", 32'({d0, rdy[0], fe[0], pe[0], ov[0], bsy[0]}), 32'({8'h22, 5'b10000}));

    send_frame(0, 9'h05A, 1'b0, 2'b11, 5, 1'b0);
    check("midframe_reset_u0", 32'({d0, rdy[0], fe[0], pe[0], ov[0], bsy[0]}), 0);
    tick();

    send_frame(2, 9'h01F, 1'b0, 2'b11, -1, 1'b0);
    check("o1f_data", 32'(d2), 32'h1F);
    check("o1f_ready", 32'(rdy[2]), 1);
    check("o1f_errors", 32'({fe[2], pe[2], ov[2]}), 0);
    send_frame(2, 9'h01F, 1'b0, 2'b01, -1, 1'b0);
    check("o1f_second_stop_framing", 32'(fe[2]), 1);
    check("o1f_second_stop_parity", 32'(pe[2]), 0);

    for (int i = 0; i < 3; i++) begin
      rnd_done = 1'b0;
      fork
        begin
          random_frames(i, 30);
          rnd_done = 1'b1;
        end
        begin
          while (!rnd_done) begin
            tick();
            rd[i] = ($urandom % 6 == 0);
          end
          rd[i] = 1'b0;
        end
      join
      repeat (4) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
